// File: rtl/freq_div_ctrl.sv
// Run-time divide-by-2N clock controller with start, glitch-free stop and divisor reprogramming.
// Optional macro FREQ_DIV_CTRL_SYNC_EN: defer divisor updates made while busy to the next terminal count.
module freq_div_ctrl #(
    parameter int WIDTH       = 26,
    parameter int DEFAULT_DIV = 20000000
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic             pending
);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_e;

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic [WIDTH-1:0] new_div;
    logic             accept;
    logic             tc;

`ifdef FREQ_DIV_CTRL_SYNC_EN
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] pdiv_q, pdiv_d;

    assign cfg_ready = ~pend_q;
    assign pending   = pend_q;
`else
    assign cfg_ready = 1'b1;
    assign pending   = 1'b0;
`endif

    assign clk_out = clk_q;
    assign tick    = tick_q;
    assign busy    = (state_q != IDLE);

    always_comb begin
        new_div = (cfg_div == '0) ? ONE : cfg_div;
        accept  = cfg_valid & cfg_ready;
        tc      = (state_q != IDLE) && (cnt_q == div_q - ONE);

        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        clk_d   = clk_q;
        tick_d  = 1'b0;
`ifdef FREQ_DIV_CTRL_SYNC_EN
        pend_d  = pend_q;
        pdiv_d  = pdiv_q;
`endif

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                clk_d = 1'b0;
                if (en) state_d = RUN;
            end
            RUN: begin
                if (!en && !clk_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    if (tc) begin
                        cnt_d  = '0;
                        clk_d  = ~clk_q;
                        tick_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                    // High phase must finish: drop straight to IDLE only on the falling TC.
                    if (!en) state_d = tc ? IDLE : STOP;
                end
            end
            STOP: begin
                if (tc) begin
                    cnt_d  = '0;
                    clk_d  = ~clk_q;
                    tick_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
                if (en)      state_d = RUN;
                else if (tc) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                clk_d   = 1'b0;
            end
        endcase

`ifdef FREQ_DIV_CTRL_SYNC_EN
        if (state_q == IDLE) begin
            if (accept) div_d = new_div;
        end else if (tc || state_d == IDLE) begin
            if (pend_q) begin
                div_d  = pdiv_q;
                pend_d = 1'b0;
            end else if (accept) begin
                div_d = new_div;
            end
        end else if (accept) begin
            pdiv_d = new_div;
            pend_d = 1'b1;
        end
`else
        if (accept) begin
            div_d = new_div;
            if (state_q != IDLE) begin
                // Restart the current half-period at the same level.
                cnt_d  = '0;
                clk_d  = clk_q;
                tick_d = 1'b0;
                if (state_d == IDLE && clk_q) state_d = STOP;
            end
        end
`endif
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= DEF_DIV;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
        end
    end

`ifdef FREQ_DIV_CTRL_SYNC_EN
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 1'b0;
            pdiv_q <= '0;
        end else begin
            pend_q <= pend_d;
            pdiv_q <= pdiv_d;
        end
    end
`endif

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Directed bench for freq_div_ctrl at WIDTH=8, DEFAULT_DIV=4; covers both FREQ_DIV_CTRL_SYNC_EN builds.
module tb_freq_div_ctrl;

    localparam int W = 8;

    logic         clk_in = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         cfg_valid = 1'b0;
    logic [W-1:0] cfg_div = '0;
    logic         cfg_ready, clk_out, tick, busy, pending;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk_in = ~clk_in;

    freq_div_ctrl #(.WIDTH(W), .DEFAULT_DIV(4)) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .en       (en),
        .cfg_valid(cfg_valid),
        .cfg_div  (cfg_div),
        .cfg_ready(cfg_ready),
        .clk_out  (clk_out),
        .tick     (tick),
        .busy     (busy),
        .pending  (pending)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic c, input logic t, input logic b);
        check({tag, ".clk_out"}, 32'(clk_out), 32'(c));
        check({tag, ".tick"},    32'(tick),    32'(t));
        check({tag, ".busy"},    32'(busy),    32'(b));
    endtask

    task automatic chk_reset(input string tag);
        chk3(tag, 1'b0, 1'b0, 1'b0);
        check({tag, ".pending"},   32'(pending),   32'd0);
        check({tag, ".cfg_ready"}, 32'(cfg_ready), 32'd1);
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // reset values
        #12;
        chk_reset("rst");
        #1 rst_n = 1'b1;
        step();

        // free run at default half-period 4
        en = 1'b1;
        step();
        chk3("start", 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 13; i++) begin
            step();
            chk3($sformatf("run%0d", i), 1'((i / 4) % 2), (i % 4) == 0, 1'b1);
        end

        // stop while high, one cycle into phase
        en = 1'b0;
        step(); chk3("stop1", 1'b1, 1'b0, 1'b1);
        step(); chk3("stop2", 1'b1, 1'b0, 1'b1);
        step(); chk3("stop3", 1'b0, 1'b1, 1'b0);
        step(); chk3("stop4", 1'b0, 1'b0, 1'b0);

        // stop while low
        en = 1'b1;
        step(); chk3("low0", 1'b0, 1'b0, 1'b1);
        step(); step();
        en = 1'b0;
        step(); chk3("lowstop", 1'b0, 1'b0, 1'b0);

        // reprogram to 2 while running at counter=2
        en = 1'b1;
        step(); step(); step();
        cfg_valid = 1'b1; cfg_div = 8'd2;
        step();
`ifdef FREQ_DIV_CTRL_SYNC_EN
        chk3("sync_acc", 1'b0, 1'b0, 1'b1);
        check("sync_pend", 32'(pending), 32'd1);
        check("sync_rdy",  32'(cfg_ready), 32'd0);
        cfg_div = 8'd7;
        step();
        chk3("sync_tc", 1'b1, 1'b1, 1'b1);
        check("sync_pend_clr", 32'(pending), 32'd0);
        check("sync_rdy_ret",  32'(cfg_ready), 32'd1);
        cfg_valid = 1'b0;
        step(); chk3("sync_h1", 1'b1, 1'b0, 1'b1);
        step(); chk3("sync_h2", 1'b0, 1'b1, 1'b1);
`else
        chk3("async_acc", 1'b0, 1'b0, 1'b1);
        cfg_valid = 1'b0;
        step(); chk3("async_c1", 1'b0, 1'b0, 1'b1);
        step(); chk3("async_tc", 1'b1, 1'b1, 1'b1);
        step(); chk3("async_h1", 1'b1, 1'b0, 1'b1);
        step(); chk3("async_h2", 1'b0, 1'b1, 1'b1);
`endif
        en = 1'b0;
        step(); chk3("idle2", 1'b0, 1'b0, 1'b0);

        // cfg_div=0 clamps to 1: toggle every cycle
        cfg_valid = 1'b1; cfg_div = 8'd0;
        step();
        cfg_valid = 1'b0;
        check("div0_pend", 32'(pending), 32'd0);
        en = 1'b1;
        step(); chk3("d1_0", 1'b0, 1'b0, 1'b1);
        step(); chk3("d1_1", 1'b1, 1'b1, 1'b1);
        step(); chk3("d1_2", 1'b0, 1'b1, 1'b1);
        step(); chk3("d1_3", 1'b1, 1'b1, 1'b1);

        // accept coinciding with TC
        cfg_valid = 1'b1; cfg_div = 8'd3;
        step();
`ifdef FREQ_DIV_CTRL_SYNC_EN
        chk3("tcacc", 1'b0, 1'b1, 1'b1);
        check("tcacc_pend", 32'(pending), 32'd0);
`else
        chk3("tcacc", 1'b1, 1'b0, 1'b1);
`endif
        cfg_valid = 1'b0;
        step(); check("d3_1.tick", 32'(tick), 32'd0);
        step(); check("d3_2.tick", 32'(tick), 32'd0);
        step(); check("d3_3.tick", 32'(tick), 32'd1);
`ifdef FREQ_DIV_CTRL_SYNC_EN
        check("d3_3.clk_out", 32'(clk_out), 32'd1);
`else
        check("d3_3.clk_out", 32'(clk_out), 32'd0);
`endif

        // async reset mid-phase (with a pending divisor in the sync build)
        cfg_valid = 1'b1; cfg_div = 8'd5;
        step();
        cfg_valid = 1'b0;
`ifdef FREQ_DIV_CTRL_SYNC_EN
        check("pre_rst_pend", 32'(pending), 32'd1);
`endif
        #2 rst_n = 1'b0;
        #1 chk_reset("midrst");
        #3 rst_n = 1'b1;
        step(); chk3("rst_run0", 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk3($sformatf("rst_run%0d", i), 1'((i / 4) % 2), (i % 4) == 0, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/freq_div_ctrl.md
# freq_div_ctrl

Run-time controller for the board's clock-divider path: owns a divide-by-2N counter and sequences its start, glitch-free stop and divisor reprogramming. Software/FSM logic writes a new half-period over a valid/ready handshake; the block emits the divided clock plus a one-cycle tick strobe per edge. It sits between the system clock and LED/scan/debounce logic that needs slow clocks.

## Interface
- WIDTH, 26, counter and divisor width in bits
- DEFAULT_DIV, 20000000, half-period (in clk_in cycles) active after reset; must be 1..2^WIDTH-1

- clk_in  input  1  system clock, all logic on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- en  input  1  run request; level-sensitive
- cfg_valid  input  1  new divisor offered
- cfg_div  input  WIDTH  new half-period; 0 is clamped to 1
- cfg_ready  output  1  divisor can be accepted this cycle
- clk_out  output  1  divided clock, period 2*active_div cycles
- tick  output  1  one-cycle pulse coincident with every clk_out change
- busy  output  1  state is RUN or STOP
- pending  output  1  accepted divisor not yet applied

## Operation
- Reset (async, any time, including mid-period or mid-handshake): state IDLE, counter 0, active_div=DEFAULT_DIV, pending register cleared, clk_out 0, tick 0, busy 0, pending 0, cfg_ready 1.
- Accept = cfg_valid & cfg_ready on a rising edge.
- Terminal count (TC) = RUN or STOP state with counter == active_div-1. At TC: counter<=0, clk_out toggles, tick<=1. Otherwise counter<=counter+1 in RUN/STOP, tick<=0.
- IDLE: counter held 0, clk_out 0. en=1 -> RUN (counter starts at 0). Accept in IDLE loads active_div directly; pending stays 0.
- RUN: counts. en=0 with clk_out=0 -> IDLE immediately, counter cleared, no tick. en=0 with clk_out=1 -> STOP.
- STOP: keeps counting; at TC clk_out falls to 0, tick pulses, -> IDLE. en returning to 1 in STOP -> RUN, counter not disturbed.
- clk_out never has a high phase shorter than active_div cycles; it never stops high.
- Divisor reprogramming while busy: governed by FREQ_DIV_CTRL_SYNC_EN (see Configuration).
- Arithmetic: compare uses active_div-1 in WIDTH bits; clamping guarantees active_div>=1, so div 1 toggles clk_out every cycle.

## Timing
- en sampled at edge k (IDLE): busy=1 after k; first tick/clk_out rise after edge k+active_div.
- tick and clk_out are registered; both update on the same edge.
- cfg_ready is combinational from pending state only, never from cfg_valid.
- Divisor applied at a TC takes effect for the half-period starting at that TC.
- Simultaneous accept and TC (SYNC_EN): new divisor becomes active at that TC boundary, pending not set.
- Simultaneous en fall and TC in RUN with clk_out=1: clk_out falls at that TC, state -> IDLE directly.

## Configuration
- FREQ_DIV_CTRL_SYNC_EN defined: while busy, an accepted divisor is stored, pending=1, cfg_ready=0; at next TC active_div<=stored, pending<=0, cfg_ready returns 1. Leaving busy to IDLE with pending set applies it at that transition.
- Undefined: cfg_ready tied 1, pending tied 0; accept in RUN/STOP loads active_div and clears counter on the same edge, clk_out level unchanged, no tick (current half-period restarts).

## Test plan
- Bench WIDTH=8, DEFAULT_DIV=4: reset, en=1 -> clk_out period 8 cycles, tick every 4 cycles, first rise 4 cycles after en.
- en=0 while clk_out high 1 cycle into phase -> STOP, clk_out falls 3 cycles later with tick, busy drops; en=0 while low -> busy drops next edge, no tick.
- SYNC_EN: in RUN write cfg_div=2 mid-phase -> pending=1, cfg_ready=0, second write stalls; after next TC half-period becomes 2, pending=0.
- SYNC_EN off: same write at counter=2 -> counter restarts at 0, next toggle 2 cycles later, clk_out unchanged at write.
- cfg_div=0 -> clk_out toggles every cycle (period 2); accept on TC cycle applies at that boundary.
- rst_n low mid-phase with pending=1 -> all outputs at reset values immediately, active_div back to 4, pending 0.
